// File: rtl/md_sched_pkg.sv
// Shared types and constants for the market-data feed scheduler.
//   sched_state_t : scheduler FSM states
//   feed_idx_w()  : width of a feed index for a given feed count
//   MSG_*         : msg_type encoding shared with market_data_parser
package md_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        WAIT    = 2'b10,
        RECOVER = 2'b11
    } sched_state_t;

    // A single-feed instance still needs a 1-bit index port.
    function automatic int feed_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam logic [1:0] MSG_UNDEF = 2'b00;
    localparam logic [1:0] MSG_TRADE = 2'b01;
    localparam logic [1:0] MSG_QUOTE = 2'b10;
    localparam logic [1:0] MSG_ORDER = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority requester this round (must be < N)
//   gnt_idx : first set request searching ptr, ptr+1, ... (mod N); 0 when none
//   gnt_any : at least one request is set
module rr_arbiter
    import md_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]                 req,
    input  logic [feed_idx_w(N)-1:0]     ptr,
    output logic [feed_idx_w(N)-1:0]     gnt_idx,
    output logic                         gnt_any
);

    localparam int IW = feed_idx_w(N);

    int   idx;
    logic found;

    always_comb begin
        gnt_any = |req;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < int'(N); i++) begin
            idx = int'(ptr) + i;
            if (idx >= int'(N)) begin
                idx = idx - int'(N);
            end
            if (!found && req[idx]) begin
                gnt_idx = IW'(idx);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/md_feed_scheduler.sv
// Shares one market_data_parser between NUM_FEEDS feed channels.
// Each message: arbitrate (IDLE) -> hand word to parser (ISSUE) -> wait for the
// parse result and pass it downstream (WAIT) -> release parser. A watchdog in
// WAIT aborts a stalled parse and drives ready_next until the parser is idle
// again (RECOVER); the timed-out word is dropped.
//   clk, rst                 : clock, synchronous active-high reset
//   feed_valid/data/ready    : per-feed word handshake (feed i at i*DATA_WIDTH)
//   prs_*                    : parser side (data_valid/in/ready, parse_valid, ready_next)
//   res_valid/ready/feed_id  : downstream result handshake and source tag
//   busy                     : scheduler not in IDLE
//   timeout_pulse/count      : watchdog event and saturating event count
module md_feed_scheduler
    import md_sched_pkg::*;
#(
    parameter int unsigned NUM_FEEDS      = 4,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_FEEDS-1:0]                feed_valid,
    input  logic [NUM_FEEDS*DATA_WIDTH-1:0]     feed_data,
    output logic [NUM_FEEDS-1:0]                feed_ready,
    output logic                                prs_data_valid,
    output logic [DATA_WIDTH-1:0]               prs_data_in,
    input  logic                                prs_data_ready,
    input  logic                                prs_parse_valid,
    output logic                                prs_ready_next,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic [feed_idx_w(NUM_FEEDS)-1:0]    res_feed_id,
    output logic                                busy,
    output logic                                timeout_pulse,
    output logic [CNT_WIDTH-1:0]                timeout_count
);

    localparam int IW     = feed_idx_w(NUM_FEEDS);
    localparam int WdogW  = $clog2(TIMEOUT_CYCLES) + 1;

    sched_state_t     state_q, state_d;
    logic [IW-1:0]    grant_q, grant_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

    logic [IW-1:0]    arb_idx;
    logic             arb_any;
    logic [IW-1:0]    next_idx;
    logic [NUM_FEEDS-1:0] feed_ready_raw;

    rr_arbiter #(
        .N (NUM_FEEDS)
    ) u_arb (
        .req     (feed_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // Priority moves just past the feed served last, wrapping to 0.
    assign next_idx = (grant_q == IW'(NUM_FEEDS - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_ptr_d       = rr_ptr_q;
        wdog_d         = wdog_q;
        tcnt_d         = tcnt_q;
        feed_ready_raw = '0;
        prs_data_valid = 1'b0;
        prs_data_in    = '0;
        prs_ready_next = 1'b0;
        res_valid      = 1'b0;
        res_feed_id    = '0;
        timeout_pulse  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                prs_data_valid          = 1'b1;
                prs_data_in             = feed_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                feed_ready_raw[grant_q] = prs_data_ready;
                if (prs_data_ready) begin
                    wdog_d  = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                res_valid      = prs_parse_valid;
                res_feed_id    = grant_q;
                prs_ready_next = prs_parse_valid & res_ready;
                if (prs_parse_valid && res_ready) begin
                    rr_ptr_d = next_idx;
                    state_d  = IDLE;
                end else if (!prs_parse_valid) begin
                    // A held result (downstream stall) freezes the watchdog.
                    if (wdog_q == WdogW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_pulse = 1'b1;
                        if (tcnt_q != '1) begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                        state_d = RECOVER;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            RECOVER: begin
                prs_ready_next = 1'b1;
                if (prs_data_ready) begin
                    rr_ptr_d = next_idx;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // No accept is offered while reset is applied: the word would be lost.
    assign feed_ready    = rst ? '0 : feed_ready_raw;
    assign busy          = (state_q != IDLE);
    assign timeout_count = tcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wdog_q   <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wdog_q   <= wdog_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Feeds must hold valid until accepted; no recovery is attempted.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ISSUE) begin
            assert (feed_valid[grant_q])
            else $error("md_feed_scheduler: granted feed dropped valid before accept");
        end
    end

endmodule

// File: tb/tb_md_feed_scheduler.sv
module tb_md_feed_scheduler;
    import md_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int TO = 16;
    localparam int CW = 16;
    localparam int IW = feed_idx_w(N);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      feed_valid;
    logic [N*DW-1:0]   feed_data;
    logic [N-1:0]      feed_ready;
    logic              prs_data_valid;
    logic [DW-1:0]     prs_data_in;
    logic              prs_data_ready;
    logic              prs_parse_valid;
    logic              prs_ready_next;
    logic              res_valid;
    logic              res_ready;
    logic [IW-1:0]     res_feed_id;
    logic              busy;
    logic              timeout_pulse;
    logic [CW-1:0]     timeout_count;

    md_feed_scheduler #(
        .NUM_FEEDS      (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .feed_valid      (feed_valid),
        .feed_data       (feed_data),
        .feed_ready      (feed_ready),
        .prs_data_valid  (prs_data_valid),
        .prs_data_in     (prs_data_in),
        .prs_data_ready  (prs_data_ready),
        .prs_parse_valid (prs_parse_valid),
        .prs_ready_next  (prs_ready_next),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_feed_id     (res_feed_id),
        .busy            (busy),
        .timeout_pulse   (timeout_pulse),
        .timeout_count   (timeout_count)
    );

    // Second instance: tiny watchdog and counter to reach saturation quickly.
    logic          rst2;
    logic [1:0]    fr2;
    logic          pdv2, prn2, rv2, rid2, busy2, to2;
    logic [DW-1:0] pdin2;
    logic [2:0]    tc2;

    md_feed_scheduler #(
        .NUM_FEEDS      (2),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (2),
        .CNT_WIDTH      (3)
    ) dut2 (
        .clk             (clk),
        .rst             (rst2),
        .feed_valid      (2'b11),
        .feed_data       ({64'hAAAA, 64'h5555}),
        .feed_ready      (fr2),
        .prs_data_valid  (pdv2),
        .prs_data_in     (pdin2),
        .prs_data_ready  (1'b1),
        .prs_parse_valid (1'b0),
        .prs_ready_next  (prn2),
        .res_valid       (rv2),
        .res_ready       (1'b1),
        .res_feed_id     (rid2),
        .busy            (busy2),
        .timeout_pulse   (to2),
        .timeout_count   (tc2)
    );

    // Parser stub: result 5 cycles after accept, held until ready_next.
    // In hang mode the accepted word never completes; ready_next then takes
    // it through a short recovery back to idle.
    int p_st;   // 0 idle, 1 parsing, 2 result, 3 hung, 4 recovering
    int p_cnt;
    bit hang_mode;
    assign prs_data_ready  = (p_st == 0);
    assign prs_parse_valid = (p_st == 2);

    always @(posedge clk) begin
        if (rst) begin
            p_st  <= 0;
            p_cnt <= 0;
        end else begin
            case (p_st)
                0: if (prs_data_valid) begin
                       if (hang_mode) p_st <= 3;
                       else begin p_st <= 1; p_cnt <= 3; end
                   end
                1: if (p_cnt == 0) p_st <= 2; else p_cnt <= p_cnt - 1;
                2: if (prs_ready_next) p_st <= 0;
                3: if (prs_ready_next) begin p_st <= 4; p_cnt <= 1; end
                4: if (p_cnt == 0) p_st <= 0; else p_cnt <= p_cnt - 1;
                default: p_st <= 0;
            endcase
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: where the message is, whom it belongs to, round-robin
    // pointer, watchdog age of the pending parse and timeouts so far.
    int m_phase;   // 0 arbitrate, 1 offer word, 2 await result, 3 recover
    int m_g, m_ptr, m_age, m_tc;
    bit auto_refill;
    int cyc = 0;
    int last_acc = -1, res_lat = -1, to_cyc = -1;
    int n_res = 0, obs_to = 0;
    int obs_fr[N];
    int res_log[$];

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++) begin
            if (m[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0]  e_fr;
        logic [DW-1:0] e_pdin;
        int hs;
        hs = -1;
        #1;
        if (rst) begin
            chk("feed_ready_in_reset", feed_ready, '0);
            m_phase = 0; m_g = 0; m_ptr = 0; m_age = 0; m_tc = 0;
        end else begin
            e_fr = '0;
            if (m_phase == 1 && prs_data_ready) e_fr[m_g] = 1'b1;
            e_pdin = (m_phase == 1) ? feed_data[m_g*DW +: DW] : '0;
            chk("busy", busy, m_phase != 0);
            chk("feed_ready", feed_ready, e_fr);
            chk("prs_data_valid", prs_data_valid, m_phase == 1);
            chk("prs_data_in", prs_data_in, e_pdin);
            chk("res_valid", res_valid, m_phase == 2 && prs_parse_valid);
            chk("res_feed_id", res_feed_id, (m_phase == 2) ? m_g : 0);
            chk("prs_ready_next", prs_ready_next,
                (m_phase == 2 && prs_parse_valid && res_ready) || m_phase == 3);
            chk("timeout_pulse", timeout_pulse,
                m_phase == 2 && !prs_parse_valid && m_age == TO - 1);
            chk("timeout_count", timeout_count, m_tc);

            for (int i = 0; i < N; i++) if (feed_ready[i]) obs_fr[i]++;
            if (feed_ready != 0) last_acc = cyc;
            if (res_valid && res_lat < 0) res_lat = cyc - last_acc;
            if (timeout_pulse) begin obs_to++; to_cyc = cyc; end
            if (res_valid && res_ready) begin n_res++; res_log.push_back(int'(res_feed_id)); end

            case (m_phase)
                0: begin
                    m_g = pick(feed_valid, m_ptr);
                    if (m_g >= 0) m_phase = 1; else m_g = 0;
                end
                1: if (prs_data_ready) begin hs = m_g; m_age = 0; m_phase = 2; end
                2: begin
                    if (prs_parse_valid && res_ready) begin
                        m_ptr = (m_g + 1) % N; m_phase = 0;
                    end else if (!prs_parse_valid) begin
                        if (m_age == TO - 1) begin
                            m_tc = (m_tc == (1 << CW) - 1) ? m_tc : m_tc + 1;
                            m_phase = 3;
                        end else m_age++;
                    end
                end
                default: if (prs_data_ready) begin m_ptr = (m_g + 1) % N; m_phase = 0; end
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs >= 0) begin
            if (auto_refill) feed_data[hs*DW +: DW] = {$urandom, $urandom};
            else feed_valid[hs] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_results(input int target, input int limit);
        int k;
        k = 0;
        while (n_res < target && k < limit) begin step(); k++; end
        chk("result_within_budget", n_res >= target, 1'b1);
    endtask

    initial begin
        int fall, acc0, k, base;
        rst = 1'b1; rst2 = 1'b1;
        feed_valid = '0; feed_data = '0; res_ready = 1'b1;
        hang_mode = 1'b0; auto_refill = 1'b0;
        m_phase = 0; m_g = 0; m_ptr = 0; m_age = 0; m_tc = 0;
        for (int i = 0; i < N; i++) obs_fr[i] = 0;
        @(posedge clk); #1;
        do_reset();
        step();

        // Single feed 2, word 1.
        feed_data[2*DW +: DW] = 64'h0000_0000_0000_0001;
        feed_valid = 4'b0100;
        res_lat = -1;
        fall = -1;
        base = cyc;
        for (int i = 0; i < 20 && fall < 0; i++) begin
            step();
            if (busy === 1'b0) fall = cyc - base;
        end
        chk("busy_fall_cycles", fall, 7);
        chk("accept_to_result", res_lat, 5);
        chk("single_feed_obs_ready", obs_fr[2], 1);
        chk("single_feed_id", res_log[res_log.size() - 1], 2);

        // All feeds continuously valid: strict rotation.
        do_reset();
        auto_refill = 1'b1;
        res_log.delete();
        n_res = 0;
        for (int i = 0; i < N; i++) begin
            obs_fr[i] = 0;
            feed_data[i*DW +: DW] = {$urandom, $urandom};
        end
        feed_valid = '1;
        run_results(8, 100);
        feed_valid = '0;
        auto_refill = 1'b0;
        for (int i = 0; i < 8 && i < res_log.size(); i++) chk("rotation_id", res_log[i], i % N);
        for (int i = 0; i < N; i++) chk("rotation_ready_count", obs_fr[i], 2);
        step();

        // Downstream stall for 30 cycles never times out.
        feed_data[1*DW +: DW] = {$urandom, $urandom};
        feed_valid[1] = 1'b1;
        res_ready = 1'b0;
        obs_to = 0;
        k = 0;
        while (res_valid !== 1'b1 && k < 20) begin step(); k++; end
        chk("stall_result_seen", res_valid, 1'b1);
        repeat (30) step();
        chk("stall_no_timeout", obs_to, 0);
        res_ready = 1'b1;
        run_results(n_res + 1, 10);
        chk("stall_result_id", res_log[res_log.size() - 1], 1);
        feed_data[3*DW +: DW] = {$urandom, $urandom};
        feed_valid[3] = 1'b1;
        run_results(n_res + 1, 20);
        chk("after_stall_id", res_log[res_log.size() - 1], 3);

        // Parser hangs on feed 0: timeout, recover, next grant to feed 1.
        hang_mode = 1'b1;
        feed_data[0*DW +: DW] = {$urandom, $urandom};
        feed_data[1*DW +: DW] = {$urandom, $urandom};
        feed_valid = 4'b0011;
        acc0 = last_acc;
        k = 0;
        while (last_acc == acc0 && k < 10) begin step(); k++; end
        hang_mode = 1'b0;
        acc0 = last_acc;
        k = 0;
        while (obs_to == 0 && k < 40) begin step(); k++; end
        chk("timeout_seen", obs_to, 1);
        chk("timeout_wait_cycle", to_cyc - acc0, 16);
        step();
        chk("timeout_count_one", timeout_count, 1);
        run_results(n_res + 1, 40);
        chk("after_timeout_id", res_log[res_log.size() - 1], 1);
        chk("timeout_once_only", obs_to, 1);

        // Reset while waiting, feeds 1 and 3 pending.
        auto_refill = 1'b1;
        feed_valid = 4'b1010;
        acc0 = last_acc;
        k = 0;
        while (last_acc == acc0 && k < 10) begin step(); k++; end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_reset_busy", busy, 1'b0);
        chk("post_reset_count", timeout_count, 0);
        acc0 = last_acc;
        k = 0;
        while (last_acc == acc0 && k < 10) begin step(); k++; end
        chk("post_reset_first_grant", obs_fr[1] > 0 && last_acc != acc0, 1'b1);
        run_results(n_res + 1, 20);
        chk("post_reset_result_id", res_log[res_log.size() - 1], 1);
        feed_valid = '0;
        auto_refill = 1'b0;

        // Randomized traffic, stalls and hangs.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!feed_valid[i] && $urandom_range(0, 3) == 0) begin
                    feed_data[i*DW +: DW] = {$urandom, $urandom};
                    feed_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            hang_mode = ($urandom_range(0, 9) == 0);
            step();
        end
        hang_mode = 1'b0;
        res_ready = 1'b1;

        // Counter saturation on the small instance.
        rst2 = 1'b0;
        k = 0;
        repeat (80) begin
            @(posedge clk); #1;
            chk("sat_count", tc2, (k > 7) ? 7 : k);
            if (to2) k++;
        end
        chk("sat_many_timeouts", k > 8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/md_feed_scheduler.md
Name: md_feed_scheduler

Overview:
- Shares one market_data_parser instance between NUM_FEEDS upstream feed channels using round-robin arbitration.
- Sequences each message through the parser: issue the word, wait for parse_valid, hand the result downstream, then release the parser with ready_next.
- Tags every parsed result with its source feed.
- Detects a stalled parse with a watchdog and recovers the parser to IDLE.

Parameters:
- NUM_FEEDS, 4, number of requesting feed channels (≥2)
- DATA_WIDTH, 64, width of one feed message word; matches the parser
- TIMEOUT_CYCLES, 16, WAIT cycles without parse_valid before a timeout is declared
- CNT_WIDTH, 16, width of the saturating timeout counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- feed_valid  in  NUM_FEEDS  per-feed word valid
- feed_data  in  NUM_FEEDS*DATA_WIDTH  per-feed words, feed i at [i*DATA_WIDTH +: DATA_WIDTH]
- feed_ready  out  NUM_FEEDS  per-feed accept, one-hot or zero
- prs_data_valid  out  1  to parser data_valid
- prs_data_in  out  DATA_WIDTH  to parser data_in
- prs_data_ready  in  1  from parser data_ready
- prs_parse_valid  in  1  from parser parse_valid
- prs_ready_next  out  1  to parser ready_next
- res_valid  out  1  parsed result available (symbol/price/quantity/msg_type are taken directly from the parser)
- res_ready  in  1  downstream accepts result
- res_feed_id  out  $clog2(NUM_FEEDS)  source feed of the current result
- busy  out  1  high whenever state != IDLE
- timeout_pulse  out  1  one-cycle pulse when a timeout is declared
- timeout_count  out  CNT_WIDTH  saturating count of timeouts

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, grant_idx=0, rr_ptr=0, wdog=0, timeout_count=0.
  - All outputs 0 (prs_data_in=0).
  - The parser is reset from the same source (its rst_n = ~rst), so a reset mid-message aborts both blocks together. The in-flight word is lost; no feed_ready is issued during reset.
- Feed rule: a feed holds valid and data stable until its feed_ready handshake. The scheduler never drops a presented word.
- IDLE:
  - If any feed_valid is set, register grant_idx = first set bit searching rr_ptr, rr_ptr+1, … (mod NUM_FEEDS), then go to ISSUE.
  - Otherwise remain in IDLE.
- ISSUE:
  - prs_data_valid=1, prs_data_in=feed_data[grant_idx].
  - feed_ready[grant_idx] = prs_data_ready (combinational).
  - On prs_data_valid & prs_data_ready, clear wdog and go to WAIT.
- WAIT:
  - res_valid = prs_parse_valid; res_feed_id = grant_idx (stable for the whole WAIT).
  - prs_ready_next = prs_parse_valid & res_ready.
  - If prs_parse_valid & res_ready: rr_ptr = grant_idx+1 (mod NUM_FEEDS), go to IDLE.
  - If prs_parse_valid=0: wdog increments.
  - If wdog reaches TIMEOUT_CYCLES-1 with prs_parse_valid still 0: timeout_pulse=1 that cycle, timeout_count += 1 (saturating at all-ones), go to RECOVER.
  - A downstream stall (parse_valid=1, res_ready=0) never times out.
- RECOVER:
  - prs_ready_next=1, res_valid=0.
  - When prs_data_ready=1 (parser back in IDLE), set rr_ptr = grant_idx+1 and go to IDLE.
  - The timed-out word is discarded and is not re-issued.
- Latency: word accepted at cycle t (ISSUE handshake) → res_valid earliest at t+5.
  - Minimum message period is 7 cycles: IDLE 1 + ISSUE 1 + WAIT 5 with res_ready=1.
- Fairness: with all feeds continuously valid, grants rotate 0,1,2,3,0,… No feed waits more than NUM_FEEDS-1 messages.
- Simultaneous events: a new feed_valid arriving during WAIT/RECOVER is only sampled in IDLE. A feed dropping valid (illegal) while granted in ISSUE is a protocol error; assertion only, no recovery.
- Single-feed edge case: with only feed k valid, consecutive messages all grant k. rr_ptr wrap: NUM_FEEDS-1 → 0.
- Outputs busy, res_valid, feed_ready and prs_ready_next are combinational from state and registered indices. No combinational path from feed_valid to any output.

Decomposition:
- md_sched_pkg holds:
  - enum sched_state_t {IDLE, ISSUE, WAIT, RECOVER} (logic [1:0])
  - function feed_idx_w(n) = $clog2(n)
  - the msg_type encoding constants shared with the parser (00 undef, 01 trade, 10 quote, 11 order)
- Sub-module rr_arbiter (parameter N): purely combinational.
  - Inputs: req[N] and ptr.
  - Outputs: gnt_idx and gnt_any.
  - Instantiated once and unit-testable alone.

Test Plan:
- Single feed 2 sends 0x0000_0000_0000_0001 with res_ready=1 → feed_ready[2] pulses in ISSUE; res_valid 5 cycles after accept; res_feed_id=2; parser msg_type=01; busy falls 7 cycles after feed_valid rose.
- All 4 feeds continuously valid, 8 messages → res_feed_id sequence 0,1,2,3,0,1,2,3; each feed_ready pulses exactly twice.
- res_ready held 0 for 30 cycles after parse_valid → res_valid and res_feed_id stable, prs_ready_next=0, timeout_pulse never asserted; release res_ready → one transfer, next grant proceeds.
- Parser stub holds parse_valid=0 → timeout_pulse exactly at WAIT cycle 16; timeout_count=1; RECOVER asserts prs_ready_next until prs_data_ready; the next grant goes to feed grant_idx+1.
- rst asserted in WAIT with feeds 1 and 3 valid → next cycle all outputs 0, state IDLE; after release the first grant is feed 1 (rr_ptr=0).
- Force 65536 timeouts with CNT_WIDTH=16 → timeout_count saturates at 0xFFFF and does not wrap.
